// File: rtl/memctrl.sv
// memctrl: arbitrates one byte-wide synchronous RAM port between the
// instruction fetch stream and serialised 1/2/4-byte MEM loads and stores.
// IF owns the port whenever no MEM transaction is in flight.
module memctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,          // asynchronous, active low
    // instruction fetch side
    input  logic [31:0]       if_addr_i,
    output logic [7:0]        if_data_o,
    // MEM stage side
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [31:0]       mem_addr_i,
    input  logic [1:0]        mem_len_i,
    input  logic [31:0]       mem_wdata_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_done_o,
    output logic              stall_req_o,
    // RAM port
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    input  logic [7:0]        ram_din_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,     // issue load addresses
        S_RW,     // capture the final load byte
        S_WR,     // write store bytes
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_base;      // only the RAM-visible address bits matter
    logic [31:0]         r_wdata;
    logic [2:0]          r_n;         // transaction length in bytes: 1, 2 or 4
    logic [2:0]          r_ic;        // bytes issued so far
    logic [1:0]          r_cc;        // next load lane to capture
    logic [31:0]         r_rdata;

    logic [2:0]          w_len_n;
    logic [ADDR_W-1:0]   w_addr;
    logic                w_last;
    logic                w_busy;
    logic                w_unused;

    // Address bits above the RAM window are intentionally dropped; the
    // base + offset add wraps silently at the top of the RAM.
    assign w_unused = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};

    assign w_addr    = r_base + ADDR_W'(r_ic);
    assign w_last    = (r_ic == r_n - 3'd1);
    assign w_busy    = (r_state == S_RD) || (r_state == S_RW) || (r_state == S_WR);

    // IF sees the RAM read data directly; it simply ignores it while stalled.
    assign if_data_o   = ram_din_i;
    assign mem_rdata_o = r_rdata;

    // Stall is gated by reset so that it drops the instant reset asserts.
    assign stall_req_o = rst & (((r_state == S_IDLE) & mem_req_i) | w_busy);

    // Decode the size code into a byte count.
    always_comb begin
        case (mem_len_i)
            2'b00:   w_len_n = 3'd1;
            2'b01:   w_len_n = 3'd2;
            default: w_len_n = 3'd4;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of block order.
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next_state;
    end

    // Next-state and RAM port drive.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned (no latches).
        w_next_state = r_state;
        ram_a_o      = if_addr_i[ADDR_W-1:0];
        ram_dout_o   = 8'h00;
        ram_wr_o     = 1'b0;
        mem_done_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (mem_req_i) w_next_state = mem_we_i ? S_WR : S_RD;
            end
            S_RD: begin
                ram_a_o = w_addr;
                if (w_last) w_next_state = S_RW;
            end
            S_RW: begin
                ram_a_o      = w_addr;
                w_next_state = S_DONE;
            end
            S_WR: begin
                ram_a_o    = w_addr;
                ram_dout_o = r_wdata[{r_ic[1:0], 3'b000} +: 8];
                ram_wr_o   = 1'b1;
                if (w_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                // mem_req_i is still high here; it is deliberately ignored.
                mem_done_o   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Transaction latch, issue/capture counters and load data assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base  <= '0;
            r_wdata <= '0;
            r_n     <= 3'd1;
            r_ic    <= '0;
            r_cc    <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        r_base  <= mem_addr_i[ADDR_W-1:0];
                        r_wdata <= mem_wdata_i;
                        r_n     <= w_len_n;
                        r_ic    <= '0;
                        r_cc    <= '0;
                        if (!mem_we_i) r_rdata <= '0;
                    end
                end
                S_RD: begin
                    r_ic <= r_ic + 3'd1;
                    // RAM data lags its address by one cycle, so the first
                    // RD cycle has nothing to capture yet.
                    if (r_ic != 3'd0) begin
                        r_rdata[{r_cc, 3'b000} +: 8] <= ram_din_i;
                        r_cc                         <= r_cc + 2'd1;
                    end
                end
                S_RW: begin
                    r_rdata[{r_cc, 3'b000} +: 8] <= ram_din_i;
                    r_cc                         <= r_cc + 2'd1;
                end
                S_WR: begin
                    r_ic <= r_ic + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
